inst_fetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 30 +++
 rtl/inst_fetch_if_id_reg.sv | 50 +++++
 rtl/inst_fetch.sv | 167 ++++++++++++++++
 tb/tb_inst_fetch.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS pipeline front end.
// Holds the instruction constants, the default fetch addresses, the
// instruction-fetch FSM encoding and a small PC helper.
package cpu_pkg;

    // Encoding of a pipeline bubble (sll $0,$0,0).
    localparam logic [31:0] NOP_INST       = 32'h0000_0000;

    // Default fetch addresses; the fetch stage exposes both as parameters.
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0180;

    // Instruction-fetch FSM encoding, kept as plain constants so that
    // legacy code comparing raw state bits keeps working.
    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t S_IDLE = 2'd0;
    localparam fetch_state_t S_RUN  = 2'd1;
    localparam fetch_state_t S_HALT = 2'd2;

    // Sequential next PC; 32-bit unsigned, wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // True when a byte address is not word aligned.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register.
// Holds the fetched instruction, its PC and a valid flag. Controls:
// bubble (highest priority) inserts an empty slot, load captures the
// incoming word, neither holds the current contents.
// Optional macro IF_ADDR_ERR_EN adds the id_adel address-error flag.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        bubble,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
`ifdef IF_ADDR_ERR_EN
    input  logic        in_adel,
    output logic        id_adel,
`endif
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    // Pipeline register update: bubble over load over hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= 32'h0000_0000;
`ifdef IF_ADDR_ERR_EN
            id_adel  <= 1'b0;
`endif
        end else if (bubble) begin
            id_valid <= 1'b0;
            id_inst  <= NOP_INST;
            id_pc    <= 32'h0000_0000;
`ifdef IF_ADDR_ERR_EN
            id_adel  <= 1'b0;
`endif
        end else if (load) begin
            id_valid <= 1'b1;
            id_inst  <= in_inst;
            id_pc    <= in_pc;
`ifdef IF_ADDR_ERR_EN
            id_adel  <= in_adel;
`endif
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage of the single-issue MIPS pipeline.
// Owns the PC, drives the combinational instruction memory and feeds the
// IF/ID register. Handles stall, branch/jump redirect with a non-squashed
// delay slot, exception flush to EXC_VECTOR and a sticky halt.
// Optional macro IF_ADDR_ERR_EN: misaligned PCs are reported on id_adel
// instead of being fetched, and the PC parks until the next flush.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_ce,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    input  logic        halt_req,
`ifdef IF_ADDR_ERR_EN
    output logic        id_adel,
`endif
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic         pend_v;
    logic         pend_v_nxt;
    logic [31:0]  pend_pc;
    logic [31:0]  pend_pc_nxt;
    logic         ce;
    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  cap_inst;
`ifdef IF_ADDR_ERR_EN
    logic         cap_adel;
    logic         misalign;

    assign misalign = pc_misaligned(pc);
`endif

    assign imem_addr = pc;
    assign imem_ce   = ce;

    // Next-state, next-PC and IF/ID control for the fetch FSM.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pend_v_nxt  = pend_v;
        pend_pc_nxt = pend_pc;
        ce          = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        cap_inst    = imem_data;
`ifdef IF_ADDR_ERR_EN
        cap_adel    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                // One quiet cycle after reset before the first fetch.
                state_nxt = S_RUN;
            end
            S_RUN: begin
`ifdef IF_ADDR_ERR_EN
                ce = ~misalign;
`else
                ce = 1'b1;
`endif
                if (flush) begin
                    // Exception: restart at the vector, drop the fetched word
                    // and any redirect still waiting behind a stall.
                    pc_nxt      = EXC_VECTOR;
                    ifid_bubble = 1'b1;
                    pend_v_nxt  = 1'b0;
                end else begin
                    if (halt_req) begin
                        state_nxt = S_HALT;
                    end
`ifdef IF_ADDR_ERR_EN
                    if (misalign) begin
                        // Report the bad address as a valid slot with no
                        // instruction; the PC parks here until a flush.
                        if (!stall) begin
                            ifid_load = 1'b1;
                            cap_inst  = NOP_INST;
                            cap_adel  = 1'b1;
                        end
                    end else
`endif
                    if (halt_req) begin
                        // The word fetched this cycle still goes down the pipe;
                        // the PC stays put for the halt.
                        ifid_load = ~stall;
                    end else if (stall) begin
                        // Remember a redirect issued while ID is stalled; the
                        // newest target wins.
                        if (redirect) begin
                            pend_v_nxt  = 1'b1;
                            pend_pc_nxt = redirect_pc;
                        end
                    end else if (pend_v || redirect) begin
                        // Current word is the delay slot and is kept.
                        pc_nxt     = redirect ? redirect_pc : pend_pc;
                        pend_v_nxt = 1'b0;
                        ifid_load  = 1'b1;
                    end else begin
                        pc_nxt    = pc_inc(pc);
                        ifid_load = 1'b1;
                    end
                end
            end
            S_HALT: begin
                // Nothing fetched while halted; only an exception wakes us.
                ifid_bubble = 1'b1;
                if (flush) begin
                    state_nxt  = S_RUN;
                    pc_nxt     = EXC_VECTOR;
                    pend_v_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM state, PC and pending-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            pend_v  <= 1'b0;
            pend_pc <= 32'h0000_0000;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            pend_v  <= pend_v_nxt;
            pend_pc <= pend_pc_nxt;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ifid_load),
        .bubble   (ifid_bubble),
        .in_inst  (cap_inst),
        .in_pc    (pc),
`ifdef IF_ADDR_ERR_EN
        .in_adel  (cap_adel),
        .id_adel  (id_adel),
`endif
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .id_pc    (id_pc)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch (default build, IF_ADDR_ERR_EN undefined).
// A combinational memory model answers every fetch; each fetch address the
// bench expects to reach ID is queued and matched when it appears on id_*.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ce;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        flush = 1'b0;
    logic        halt_req = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] sbq[$];
    logic        last_v = 1'b0;
    logic [31:0] last_pc = 32'h0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_ce     (imem_ce),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .halt_req    (halt_req),
        .id_valid    (id_valid),
        .id_inst     (id_inst),
        .id_pc       (id_pc)
    );

    // Memory contents: word index i holds 0x1000_0000 + i*0x0001_0001.
    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] i;
        i = {24'd0, a[9:2]};
        return 32'h1000_0000 + (i << 16) + i;
    endfunction

    assign imem_data = memword(imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the fetch address and queue it as the next expected ID entry.
    task automatic fetch(input logic [31:0] a);
        chk("imem_addr", imem_addr, a);
        chk("imem_ce", 32'(imem_ce), 32'd1);
        sbq.push_back(a);
    endtask

    // Scoreboard: every newly registered ID entry must match the queue head.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_v = 1'b0;
        end else begin
            if (id_valid && (!last_v || id_pc != last_pc)) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_id_pc", id_pc, 32'hDEAD_BEEF);
                end else begin
                    logic [31:0] e;
                    e = sbq.pop_front();
                    chk("sb_id_pc", id_pc, e);
                    chk("sb_id_inst", id_inst, memword(e));
                end
            end
            last_v  = id_valid;
            last_pc = id_pc;
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_ce", 32'(imem_ce), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_ce", 32'(imem_ce), 32'd0);

        // Sequential fetch, then redirect with delay slot at 0x10
        step(); fetch(32'h0);
        step(); fetch(32'h4);
        step(); fetch(32'h8);
        step(); fetch(32'hC);
        step(); fetch(32'h10);
        redirect = 1'b1; redirect_pc = 32'h20;
        step(); redirect = 1'b0; fetch(32'h20);
        step(); fetch(32'h24);
        step(); fetch(32'h28);

        // Three-cycle stall with a redirect to 0x40 during it
        step();
        chk("stall_addr0", imem_addr, 32'h2C);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            redirect = 1'b0;
            chk("stall_addr", imem_addr, 32'h2C);
            chk("stall_id_pc", id_pc, 32'h28);
            chk("stall_id_valid", 32'(id_valid), 32'd1);
        end
        stall = 1'b0;
        fetch(32'h2C);
        step(); fetch(32'h40);
        step(); fetch(32'h44);
        redirect = 1'b1; redirect_pc = 32'h8;

        // Flush together with stall at pc=8, pending redirect discarded
        step(); redirect = 1'b0;
        chk("pre_flush_addr", imem_addr, 32'h8);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h60;
        step(); redirect = 1'b0;
        chk("flush_stall_addr", imem_addr, 32'h8);
        chk("flush_stall_id_pc", id_pc, 32'h44);
        flush = 1'b1;
        step(); flush = 1'b0; stall = 1'b0;
        chk("flush_id_valid", 32'(id_valid), 32'd0);
        chk("flush_id_inst", id_inst, 32'h0);
        fetch(32'h180);
        step(); fetch(32'h184);
        step(); fetch(32'h188);
        redirect = 1'b1; redirect_pc = 32'h94;

        // Halt at 0x94
        step(); redirect = 1'b0; fetch(32'h94);
        halt_req = 1'b1;
        step(); halt_req = 1'b0;
        chk("halt_ce", 32'(imem_ce), 32'd0);
        chk("halt_last_valid", 32'(id_valid), 32'd1);
        chk("halt_last_pc", id_pc, 32'h94);
        for (int i = 0; i < 20; i++) begin
            step();
            halt_req = (i == 5);
            redirect = (i == 5);
            redirect_pc = 32'h300;
            chk("halted_ce", 32'(imem_ce), 32'd0);
            chk("halted_id_valid", 32'(id_valid), 32'd0);
        end
        halt_req = 1'b0; redirect = 1'b0;
        flush = 1'b1;
        step(); flush = 1'b0; fetch(32'h180);
        step(); fetch(32'h184);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;

        // PC wrap at the top of the address space
        step(); redirect = 1'b0; fetch(32'hFFFF_FFFC);
        step(); fetch(32'h0);
        step(); fetch(32'h4);

        // Asynchronous reset with a redirect pending behind a stall
        step();
        chk("pre_rst_addr", imem_addr, 32'h8);
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h70;
        step(); redirect = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_id_valid", 32'(id_valid), 32'd0);
        chk("arst_id_inst", id_inst, 32'h0);
        chk("arst_id_pc", id_pc, 32'h0);
        chk("arst_ce", 32'(imem_ce), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_sb_left", 32'(sbq.size()), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_idle_ce", 32'(imem_ce), 32'd0);
        step(); fetch(32'h0);
        step(); fetch(32'h4);
        step();
        chk("post_rst_addr", imem_addr, 32'h8);
        stall = 1'b1;
        step();
        step();
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
